// File: rtl/ro_puf_pkg.sv
// ro_puf_pkg
// Shared definitions for the ring-oscillator PUF vote sequencer.
// Contents:
//   state_t / ST_*   : FSM state type and its 3-bit state constants
//   DEF_*            : default parameter values for the top level
//   maj_thresh()     : majority threshold. A bit wins the vote when its
//                      ones count is strictly greater than this value.
package ro_puf_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_CLEAR = 3'd1;
    localparam state_t ST_EVAL  = 3'd2;
    localparam state_t ST_SHIFT = 3'd3;
    localparam state_t ST_WRITE = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

    localparam int DEF_SIG_BITS = 128;
    localparam int DEF_VOTES    = 5;
    localparam int DEF_TIMEOUT  = 4096;

    function automatic int maj_thresh(input int votes);
        return votes / 2;
    endfunction

endpackage

// File: rtl/ro_puf_vote.sv
// ro_puf_vote
// Accumulates the compare results of one challenge and reduces them to a
// single majority bit.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   clr        : clears the ones count and the vote index
//   acc_en     : accept bit_in as one more vote
//   bit_in     : compare result to accumulate
//   last_vote  : the vote currently being collected is the final one
//   maj_bit    : ones count is above the majority threshold
module ro_puf_vote
    import ro_puf_pkg::*;
#(
    parameter int VOTES = DEF_VOTES
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic acc_en,
    input  logic bit_in,
    output logic last_vote,
    output logic maj_bit
);

    localparam int ONES_W = $clog2(VOTES + 1);
    localparam int VI_W   = $clog2(VOTES + 1);

    logic [ONES_W-1:0] ones;
    logic [VI_W-1:0]   vote_idx;

    // Counting register pair. The vote index may step to VOTES after the
    // final vote; the widths leave room for that, and the following clear
    // brings it back to zero before it is used again.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ones     <= '0;
            vote_idx <= '0;
        end else if (clr) begin
            ones     <= '0;
            vote_idx <= '0;
        end else if (acc_en) begin
            ones     <= ones + ONES_W'(bit_in);
            vote_idx <= vote_idx + VI_W'(1);
        end
    end

    // The strict comparison against VOTES/2 is enough because VOTES is odd,
    // so a tie cannot occur.
    assign last_vote = (vote_idx == VI_W'(VOTES - 1));
    assign maj_bit   = (ones > ONES_W'(maj_thresh(VOTES)));

endmodule

// File: rtl/ro_puf_vote_ctrl.sv
// ro_puf_vote_ctrl
// Sequencer for the RO PUF. For every challenge it runs VOTES counter
// evaluations, majority-votes the results, shifts the bit into the signature
// register, and at the end writes the signature word to SRAM.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   start, sig_sel  : run request (honoured in IDLE/DONE) and SRAM word
//   cnt_done/cnt_bit: compare-finished pulse and its result
//   roen, cnt_clr   : RO pair enable and counter clear pulse
//   shift_reg_en/shift_bit : signature shift strobe and voted bit
//   ram_wren/ram_addr      : SRAM write strobe and latched word address
//   challenge_cnt   : current challenge index for the RO pair mux
//   busy, done, err : run status; err is a sticky watchdog flag
module ro_puf_vote_ctrl
    import ro_puf_pkg::*;
#(
    parameter int SIG_BITS = DEF_SIG_BITS,
    parameter int VOTES    = DEF_VOTES,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int ADDR_W   = 4,
    parameter int CH_W     = $clog2(SIG_BITS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] sig_sel,
    input  logic              cnt_done,
    input  logic              cnt_bit,
    output logic              roen,
    output logic              cnt_clr,
    output logic              shift_reg_en,
    output logic              shift_bit,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [CH_W-1:0]   challenge_cnt,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int WD_W = $clog2(TIMEOUT);

    state_t          state;
    logic [WD_W-1:0] wdog;
    logic            accept_start;
    logic            vote_clr;
    logic            vote_acc;
    logic            last_vote;
    logic            maj_bit;

    assign accept_start = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign vote_clr     = accept_start || (state == ST_SHIFT);
    assign vote_acc     = (state == ST_EVAL) && cnt_done;

    ro_puf_vote #(
        .VOTES (VOTES)
    ) u_vote (
        .clk       (clk),
        .rst       (rst),
        .clr       (vote_clr),
        .acc_en    (vote_acc),
        .bit_in    (cnt_bit),
        .last_vote (last_vote),
        .maj_bit   (maj_bit)
    );

    // Main sequencer. The watchdog is zeroed in CLEAR and counts EVAL
    // cycles; the timeout branch fires on the edge that would bring it to
    // TIMEOUT-1, and a cnt_done on that same edge takes priority.
    // challenge_cnt only advances in SHIFT when it is below SIG_BITS-1,
    // so it saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            challenge_cnt <= '0;
            ram_addr      <= '0;
            err           <= 1'b0;
            wdog          <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state         <= ST_CLEAR;
                        challenge_cnt <= '0;
                        ram_addr      <= sig_sel;
                        err           <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    wdog  <= '0;
                    state <= ST_EVAL;
                end
                ST_EVAL: begin
                    wdog <= wdog + WD_W'(1);
                    if (cnt_done) begin
                        state <= last_vote ? ST_SHIFT : ST_CLEAR;
                    end else if (wdog == WD_W'(TIMEOUT - 2)) begin
                        err   <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_SHIFT: begin
                    if (challenge_cnt == CH_W'(SIG_BITS - 1)) begin
                        state <= ST_WRITE;
                    end else begin
                        challenge_cnt <= challenge_cnt + CH_W'(1);
                        state         <= ST_CLEAR;
                    end
                end
                ST_WRITE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded from the registered state only, so reset
    // forces them low immediately and no input reaches an output directly.
    always_comb begin
        roen         = (state == ST_EVAL);
        cnt_clr      = (state == ST_CLEAR);
        shift_reg_en = (state == ST_SHIFT);
        shift_bit    = (state == ST_SHIFT) && maj_bit;
        ram_wren     = (state == ST_WRITE);
        busy         = (state != ST_IDLE) && (state != ST_DONE);
        done         = (state == ST_DONE);
    end

endmodule

// File: tb/tb_ro_puf_vote_ctrl.sv
// tb_ro_puf_vote_ctrl
// Self-checking bench for ro_puf_vote_ctrl with SIG_BITS=8, VOTES=3,
// TIMEOUT=16. A behavioural counter-controller model answers each RO
// evaluation and predicts every signature bit from the votes it handed out.
module tb_ro_puf_vote_ctrl;
    import ro_puf_pkg::*;

    localparam int SIG_BITS = 8;
    localparam int VOTES    = 3;
    localparam int TIMEOUT  = 16;
    localparam int ADDR_W   = 4;
    localparam int CH_W     = 3;
    localparam int BUDGET   = 5000;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] sig_sel = '0;
    logic              cnt_done = 1'b0;
    logic              cnt_bit = 1'b0;
    logic              roen, cnt_clr, shift_reg_en, shift_bit, ram_wren;
    logic [ADDR_W-1:0] ram_addr;
    logic [CH_W-1:0]   challenge_cnt;
    logic              busy, done, err;

    int checks = 0;
    int errors = 0;

    bit                exp_bits[$];
    bit                obs_bits[$];
    int                obs_ch[$];
    int                obs_wren;
    logic [ADDR_W-1:0] obs_addr;
    int                done_idx;
    int                wd_roen;
    bit                aborted;
    logic              first_err, first_clr, first_roen, first_busy;

    ro_puf_vote_ctrl #(
        .SIG_BITS (SIG_BITS),
        .VOTES    (VOTES),
        .TIMEOUT  (TIMEOUT),
        .ADDR_W   (ADDR_W),
        .CH_W     (CH_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .sig_sel       (sig_sel),
        .cnt_done      (cnt_done),
        .cnt_bit       (cnt_bit),
        .roen          (roen),
        .cnt_clr       (cnt_clr),
        .shift_reg_en  (shift_reg_en),
        .shift_bit     (shift_bit),
        .ram_wren      (ram_wren),
        .ram_addr      (ram_addr),
        .challenge_cnt (challenge_cnt),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    // Counter-controller model plus observer. Starts a run, then at every
    // falling edge records the DUT outputs and decides what the counter
    // controller presents at the next rising edge. Votes: mode 1 all ones,
    // mode 2 pattern 1,0,0, mode 3 pattern 0,1,1, otherwise random.
    // withhold_ch never answers that challenge; reset_ch asserts reset in
    // the second EVAL cycle of that challenge; noise adds stray cnt_done
    // pulses outside EVAL and start pulses while busy.
    task automatic run_seq(input logic [ADDR_W-1:0] sel, input int dly, input int mode,
                           input int withhold_ch, input int reset_ch, input bit noise);
        int idx, ecyc, votes, sum;
        bit b, fin;
        exp_bits.delete(); obs_bits.delete(); obs_ch.delete();
        obs_wren = 0; obs_addr = '0; done_idx = -1; wd_roen = 0; aborted = 0;
        idx = 0; ecyc = 0; votes = 0; sum = 0; fin = 0;
        @(negedge clk);
        start = 1'b1; sig_sel = sel;
        while (!fin) begin
            @(negedge clk);
            start = 1'b0; cnt_done = 1'b0;
            cnt_bit = 1'($urandom_range(0, 1));
            sig_sel = ADDR_W'($urandom);
            if (idx == 0) begin
                first_err = err; first_clr = cnt_clr; first_roen = roen; first_busy = busy;
            end
            if (shift_reg_en) begin
                obs_bits.push_back(shift_bit);
                obs_ch.push_back(int'(challenge_cnt));
            end
            if (ram_wren) begin
                obs_wren++;
                obs_addr = ram_addr;
            end
            if (done) begin
                done_idx = idx;
                fin = 1;
            end else if (idx >= BUDGET) begin
                checks++; errors++;
                $display("[TB] FAIL run_budget: no done after %0d cycles, required done=1", idx);
                fin = 1;
            end else begin
                if (roen) begin
                    ecyc++;
                    if (votes / VOTES == withhold_ch) begin
                        wd_roen++;
                    end else if (votes / VOTES == reset_ch && ecyc == 2) begin
                        rst = 1'b0;
                        aborted = 1;
                        fin = 1;
                    end else if (ecyc == dly + 1) begin
                        case (mode)
                            1: b = 1'b1;
                            2: b = (votes % VOTES == 0);
                            3: b = (votes % VOTES != 0);
                            default: b = 1'($urandom_range(0, 1));
                        endcase
                        cnt_done = 1'b1; cnt_bit = b;
                        sum += int'(b); votes++;
                        if (votes % VOTES == 0) begin
                            exp_bits.push_back(2 * sum > VOTES);
                            sum = 0;
                        end
                    end
                end else begin
                    ecyc = 0;
                    if (noise && (cnt_clr || shift_reg_en) && $urandom_range(0, 1) == 1) begin
                        cnt_done = 1'b1; cnt_bit = 1'b1;
                    end
                end
                if (!fin && noise && busy && $urandom_range(0, 3) == 0) start = 1'b1;
            end
            idx++;
        end
        start = 1'b0; cnt_done = 1'b0;
    endtask

    // Outputs while reset is held from time zero, then release.
    task automatic test_reset();
        #2;
        checks++;
        if ({roen, cnt_clr, shift_reg_en, shift_bit, ram_wren, busy, done, err} !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b required 00000000",
                     {roen, cnt_clr, shift_reg_en, shift_bit, ram_wren, busy, done, err});
        end
        checks++;
        if (challenge_cnt !== '0 || ram_addr !== '0) begin
            errors++;
            $display("[TB] FAIL reset_counters: got ch=%0d addr=%0d required 0/0", challenge_cnt, ram_addr);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Full run: every vote is 1, fixed 4-cycle answer latency, word 5.
    task automatic test_all_ones();
        run_seq(4'd5, 4, 1, -1, -1, 0);
        checks++;
        if (first_clr !== 1'b1 || first_roen !== 1'b0 || first_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL start_clear: got clr=%b roen=%b busy=%b required 1/0/1",
                     first_clr, first_roen, first_busy);
        end
        checks++;
        if (obs_bits.size() != SIG_BITS) begin
            errors++;
            $display("[TB] FAIL ones_count: got %0d shifts required %0d", obs_bits.size(), SIG_BITS);
        end
        for (int i = 0; i < obs_bits.size() && i < SIG_BITS; i++) begin
            checks++;
            if (obs_bits[i] !== 1'b1 || obs_ch[i] != i) begin
                errors++;
                $display("[TB] FAIL ones_bit%0d: got bit=%b ch=%0d required 1/%0d", i, obs_bits[i], obs_ch[i], i);
            end
        end
        checks++;
        if (obs_wren != 1 || obs_addr !== 4'd5) begin
            errors++;
            $display("[TB] FAIL ones_write: got %0d writes addr=%0d required 1 at 5", obs_wren, obs_addr);
        end
        checks++;
        if (done_idx != SIG_BITS * (VOTES * (2 + 4) + 1) + 1) begin
            errors++;
            $display("[TB] FAIL ones_latency: got done at %0d required %0d",
                     done_idx, SIG_BITS * (VOTES * (2 + 4) + 1) + 1);
        end
        checks++;
        if (done !== 1'b1 || roen !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || challenge_cnt !== 3'd7) begin
            errors++;
            $display("[TB] FAIL ones_final: got done=%b roen=%b busy=%b err=%b ch=%0d required 1/0/0/0/7",
                     done, roen, busy, err, challenge_cnt);
        end
    endtask

    // Fixed minority and majority vote patterns, started from DONE.
    task automatic test_patterns();
        for (int m = 2; m <= 3; m++) begin
            int d;
            d = $urandom_range(0, 3);
            run_seq(ADDR_W'(m), d, m, -1, -1, 0);
            checks++;
            if (obs_bits.size() != SIG_BITS || done_idx != SIG_BITS * (VOTES * (2 + d) + 1) + 1) begin
                errors++;
                $display("[TB] FAIL pattern%0d_shape: got %0d shifts done at %0d required %0d/%0d",
                         m, obs_bits.size(), done_idx, SIG_BITS, SIG_BITS * (VOTES * (2 + d) + 1) + 1);
            end
            for (int i = 0; i < obs_bits.size() && i < SIG_BITS; i++) begin
                checks++;
                if (obs_bits[i] !== bit'(m == 3)) begin
                    errors++;
                    $display("[TB] FAIL pattern%0d_bit%0d: got %b required %b", m, i, obs_bits[i], m == 3);
                end
            end
        end
    endtask

    // Random votes with stray cnt_done outside EVAL and start while busy.
    task automatic test_random_noise();
        for (int r = 0; r < 2; r++) begin
            logic [ADDR_W-1:0] sel;
            int d;
            sel = ADDR_W'($urandom);
            d = $urandom_range(0, 5);
            run_seq(sel, d, 0, -1, -1, 1);
            checks++;
            if (obs_bits.size() != SIG_BITS || exp_bits.size() != SIG_BITS) begin
                errors++;
                $display("[TB] FAIL noise%0d_count: got %0d shifts required %0d", r, obs_bits.size(), SIG_BITS);
            end
            for (int i = 0; i < obs_bits.size() && i < exp_bits.size(); i++) begin
                checks++;
                if (obs_bits[i] !== exp_bits[i] || obs_ch[i] != i) begin
                    errors++;
                    $display("[TB] FAIL noise%0d_bit%0d: got bit=%b ch=%0d required %b/%0d",
                             r, i, obs_bits[i], obs_ch[i], exp_bits[i], i);
                end
            end
            checks++;
            if (obs_wren != 1 || obs_addr !== sel ||
                done_idx != SIG_BITS * (VOTES * (2 + d) + 1) + 1) begin
                errors++;
                $display("[TB] FAIL noise%0d_end: got writes=%0d addr=%0d done at %0d required 1/%0d/%0d",
                         r, obs_wren, obs_addr, done_idx, sel, SIG_BITS * (VOTES * (2 + d) + 1) + 1);
            end
        end
    endtask

    // Challenge 2 never answered: watchdog ends the run without a write.
    task automatic test_timeout();
        run_seq(4'd3, 2, 0, 2, -1, 0);
        checks++;
        if (wd_roen != TIMEOUT - 1) begin
            errors++;
            $display("[TB] FAIL timeout_len: got %0d EVAL cycles required %0d", wd_roen, TIMEOUT - 1);
        end
        checks++;
        if (err !== 1'b1 || done !== 1'b1 || roen !== 1'b0 || challenge_cnt !== 3'd2) begin
            errors++;
            $display("[TB] FAIL timeout_flags: got err=%b done=%b roen=%b ch=%0d required 1/1/0/2",
                     err, done, roen, challenge_cnt);
        end
        checks++;
        if (obs_wren != 0 || obs_bits.size() != 2) begin
            errors++;
            $display("[TB] FAIL timeout_side: got %0d writes %0d shifts required 0/2", obs_wren, obs_bits.size());
        end
    endtask

    // Second start from DONE after a timeout clears err and writes word 9.
    task automatic test_restart();
        run_seq(4'd9, 1, 0, -1, -1, 0);
        checks++;
        if (first_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL restart_err: got err=%b after start required 0", first_err);
        end
        checks++;
        if (obs_wren != 1 || obs_addr !== 4'd9 || err !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL restart_write: got writes=%0d addr=%0d err=%b done=%b required 1/9/0/1",
                     obs_wren, obs_addr, err, done);
        end
        for (int i = 0; i < obs_bits.size() && i < exp_bits.size(); i++) begin
            checks++;
            if (obs_bits[i] !== exp_bits[i]) begin
                errors++;
                $display("[TB] FAIL restart_bit%0d: got %b required %b", i, obs_bits[i], exp_bits[i]);
            end
        end
    endtask

    // Reset mid-EVAL at challenge 4, then a fresh run from challenge 0.
    task automatic test_reset_mid_eval();
        run_seq(4'd6, 4, 0, -1, 4, 0);
        #1;
        checks++;
        if (aborted != 1 || {roen, cnt_clr, shift_reg_en, shift_bit, ram_wren, busy, done, err} !== 8'h00 ||
            challenge_cnt !== '0 || ram_addr !== '0 || dut.state !== ST_IDLE) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got hit=%0d flags=%b ch=%0d addr=%0d state=%0d required 1/0/0/0/%0d",
                     aborted, {roen, cnt_clr, shift_reg_en, shift_bit, ram_wren, busy, done, err},
                     challenge_cnt, ram_addr, dut.state, ST_IDLE);
        end
        @(negedge clk);
        rst = 1'b1;
        run_seq(4'd12, 3, 0, -1, -1, 0);
        checks++;
        if (obs_ch.size() != SIG_BITS || obs_ch[0] != 0 || obs_wren != 1 || obs_addr !== 4'd12) begin
            errors++;
            $display("[TB] FAIL midreset_rerun: got %0d shifts writes=%0d addr=%0d required %0d/1/12",
                     obs_ch.size(), obs_wren, obs_addr, SIG_BITS);
        end
        for (int i = 0; i < obs_bits.size() && i < exp_bits.size(); i++) begin
            checks++;
            if (obs_bits[i] !== exp_bits[i] || obs_ch[i] != i) begin
                errors++;
                $display("[TB] FAIL midreset_bit%0d: got %b ch=%0d required %b/%0d",
                         i, obs_bits[i], obs_ch[i], exp_bits[i], i);
            end
        end
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_all_ones();
        test_patterns();
        test_random_noise();
        test_timeout();
        test_restart();
        test_reset_mid_eval();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
